// File: rtl/snake_game_pkg.sv
// Shared constants for the snake game: one-hot game status encoding and BCD score format.
// Any block that decodes Game_status imports the same constants.
package snake_game_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;
   localparam int unsigned BCD_SCORE_W = 2 * BCD_DIGIT_W;

   localparam logic [2:0] ST_START = 3'b001;
   localparam logic [2:0] ST_PLAY  = 3'b010;
   localparam logic [2:0] ST_END   = 3'b100;

   localparam logic [BCD_SCORE_W-1:0] BCD_SCORE_MAX = 8'h99;

   typedef enum logic [2:0] {
      S_START = ST_START,
      S_PLAY  = ST_PLAY,
      S_END   = ST_END
   } game_state_e;

   function automatic logic [1:0] apple_points(input logic apple_type);
      return apple_type ? 2'd2 : 2'd1;
   endfunction

endpackage

// File: rtl/bcd2_sat_adder.sv
// Two-digit BCD plus a small increment, saturating at 99.
// Inputs are assumed to be valid BCD.
module bcd2_sat_adder
   import snake_game_pkg::*;
(
   input  logic [BCD_SCORE_W-1:0] bcd_in,
   input  logic [1:0]             inc,
   output logic [BCD_SCORE_W-1:0] bcd_out
);

   logic [BCD_DIGIT_W:0]   units_raw;
   logic [BCD_DIGIT_W:0]   tens_raw;
   logic [BCD_DIGIT_W-1:0] units;
   logic                   carry;

   always_comb begin
      units_raw = {1'b0, bcd_in[BCD_DIGIT_W-1:0]} + (BCD_DIGIT_W+1)'(inc);
      carry     = (units_raw > 5'd9);
      units     = carry ? BCD_DIGIT_W'(units_raw - 5'd10) : units_raw[BCD_DIGIT_W-1:0];
      tens_raw  = {1'b0, bcd_in[BCD_SCORE_W-1:BCD_DIGIT_W]} + (BCD_DIGIT_W+1)'(carry);
      bcd_out   = {tens_raw[BCD_DIGIT_W-1:0], units};
      if (tens_raw > 5'd9) begin
         bcd_out = BCD_SCORE_MAX;
      end
   end

endmodule

// File: rtl/game_status_ctrl_module.sv
// Snake game sequencer: START/PLAY/END status, BCD score and high score,
// restart pulse into the snake/apple logic and END-screen flash enable.
//
// state   | meaning
// S_START | title screen, waiting for Key_start
// S_PLAY  | game running, apples scored, collisions end the game
// S_END   | game over, flash display, Key_start honoured after hold time
module game_status_ctrl_module
   import snake_game_pkg::*;
#(
   parameter int unsigned END_HOLD_CYCLES   = 50_000_000,
   parameter int unsigned FLASH_HALF_CYCLES = 12_500_000
) (
   input  logic                   Clk_50mhz,
   input  logic                   Rst,
   input  logic                   Key_start,
   input  logic                   Body_add_sig,
   input  logic                   Apple_type,
   input  logic                   Hit_wall_sig,
   input  logic                   Hit_body_sig,
   output logic [2:0]             Game_status,
   output logic [BCD_SCORE_W-1:0] Score_bcd,
   output logic [BCD_SCORE_W-1:0] High_score_bcd,
   output logic                   Restart_pulse,
   output logic                   Flash_sig
);

   localparam int unsigned HOLD_W  = $clog2(END_HOLD_CYCLES + 1);
   localparam int unsigned FLASH_W = $clog2(FLASH_HALF_CYCLES + 1);

   localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(END_HOLD_CYCLES);
   localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_HALF_CYCLES - 1);

   game_state_e            state;
   logic [HOLD_W-1:0]      hold_cnt;
   logic [FLASH_W-1:0]     flash_cnt;
   logic                   body_add_d;
   logic                   apple_rise;
   logic                   hold_done;
   logic                   collision;
   logic [BCD_SCORE_W-1:0] score_sum;

   assign apple_rise  = Body_add_sig & ~body_add_d;
   assign hold_done   = (hold_cnt == HOLD_MAX);
   assign collision   = Hit_wall_sig | Hit_body_sig;
   assign Game_status = state;

   bcd2_sat_adder u_score_add (
      .bcd_in  (Score_bcd),
      .inc     (apple_points(Apple_type)),
      .bcd_out (score_sum)
   );

   always_ff @(posedge Clk_50mhz) begin
      if (Rst) begin
         state          <= S_START;
         Score_bcd      <= '0;
         High_score_bcd <= '0;
         Restart_pulse  <= 1'b0;
         Flash_sig      <= 1'b0;
         hold_cnt       <= '0;
         flash_cnt      <= '0;
         body_add_d     <= 1'b0;
      end else begin
         body_add_d    <= Body_add_sig;
         Restart_pulse <= 1'b0;
         case (state)
            S_START: begin
               if (Key_start) begin
                  state         <= S_PLAY;
                  Restart_pulse <= 1'b1;
                  Score_bcd     <= '0;
               end
            end
            S_PLAY: begin
               // A collision in the same cycle as an apple rise discards the apple.
               if (collision) begin
                  state     <= S_END;
                  hold_cnt  <= '0;
                  flash_cnt <= '0;
                  Flash_sig <= 1'b1;
                  if (Score_bcd > High_score_bcd) begin
                     High_score_bcd <= Score_bcd;
                  end
               end else if (apple_rise) begin
                  Score_bcd <= score_sum;
               end
            end
            S_END: begin
               if (Key_start && hold_done) begin
                  state     <= S_START;
                  hold_cnt  <= '0;
                  flash_cnt <= '0;
                  Flash_sig <= 1'b0;
               end else begin
                  if (!hold_done) begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
                  if (flash_cnt == FLASH_LAST) begin
                     flash_cnt <= '0;
                     Flash_sig <= ~Flash_sig;
                  end else begin
                     flash_cnt <= flash_cnt + FLASH_W'(1);
                  end
               end
            end
            default: begin
               state     <= S_START;
               hold_cnt  <= '0;
               flash_cnt <= '0;
               Flash_sig <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_status_ctrl_module.sv
// Self-checking bench for game_status_ctrl_module: directed game scenarios
// followed by random play, all checked against a cycle-level game model.
module tb_game_status_ctrl_module;

   localparam int HOLD = 20;
   localparam int HALF = 4;

   logic       clk = 1'b0;
   logic       rst, key, body, typ, wall, bhit;
   logic [2:0] gs;
   logic [7:0] score, high;
   logic       pulse, flash;

   int checks   = 0;
   int failures = 0;

   // game model: 0=start 1=play 2=end, scores held as plain integers
   int m_st    = 0;
   int m_score = 0;
   int m_high  = 0;
   int m_k     = 0;
   bit m_pulse = 1'b0;
   bit m_prev  = 1'b0;

   always #10 clk = ~clk;

   game_status_ctrl_module #(
      .END_HOLD_CYCLES   (HOLD),
      .FLASH_HALF_CYCLES (HALF)
   ) dut (
      .Clk_50mhz      (clk),
      .Rst            (rst),
      .Key_start      (key),
      .Body_add_sig   (body),
      .Apple_type     (typ),
      .Hit_wall_sig   (wall),
      .Hit_body_sig   (bhit),
      .Game_status    (gs),
      .Score_bcd      (score),
      .High_score_bcd (high),
      .Restart_pulse  (pulse),
      .Flash_sig      (flash)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   task automatic model_step(input bit k, input bit b, input bit t, input bit w, input bit h, input bit r);
      bit rise;
      rise   = b && !m_prev;
      m_prev = b;
      if (r) begin
         m_st = 0; m_score = 0; m_high = 0; m_pulse = 0; m_k = 0; m_prev = 0;
      end else begin
         m_pulse = 0;
         case (m_st)
            0: if (k) begin m_st = 1; m_score = 0; m_pulse = 1; end
            1: begin
               if (w || h) begin
                  m_st = 2; m_k = 0;
                  if (m_score > m_high) m_high = m_score;
               end else if (rise) begin
                  m_score = m_score + (t ? 2 : 1);
                  if (m_score > 99) m_score = 99;
               end
            end
            default: begin
               if (k && m_k >= HOLD) m_st = 0;
               else m_k++;
            end
         endcase
      end
   endtask

   task automatic cycle(input bit k, input bit b, input bit t, input bit w, input bit h, input bit r);
      bit exp_flash;
      key = k; body = b; typ = t; wall = w; bhit = h; rst = r;
      @(posedge clk);
      model_step(k, b, t, w, h, r);
      #1;
      exp_flash = (m_st == 2) && (((m_k / HALF) % 2) == 0);
      chk("status", 32'(gs), 32'(1 << m_st));
      chk("score", 32'(score), 32'(to_bcd(m_score)));
      chk("high", 32'(high), 32'(to_bcd(m_high)));
      chk("restart", 32'(pulse), 32'(m_pulse));
      chk("flash", 32'(flash), 32'(exp_flash));
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0);
   endtask

   task automatic apple(input bit t);
      cycle(0, 1, t, 0, 0, 0);
      cycle(0, 0, t, 0, 0, 0);
   endtask

   // run END cycles until the model's hold count reaches n, bounded
   task automatic wait_end(input int n);
      int guard = 0;
      while (m_st == 2 && m_k < n && guard < 200) begin
         idle();
         guard++;
      end
      chk("end_wait_bound", 32'(guard < 200), 32'(1));
   endtask

   initial begin
      key = 0; body = 0; typ = 0; wall = 0; bhit = 0; rst = 1;

      // reset values
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      chk("rst_status", 32'(gs), 32'h1);
      chk("rst_score", 32'(score), 32'h00);
      chk("rst_high", 32'(high), 32'h00);
      chk("rst_pulse", 32'(pulse), 32'h0);
      chk("rst_flash", 32'(flash), 32'h0);
      idle();
      chk("start_hold", 32'(gs), 32'h1);

      // start a game
      cycle(1, 0, 0, 0, 0, 0);
      chk("t1_status", 32'(gs), 32'h2);
      chk("t1_pulse", 32'(pulse), 32'h1);
      chk("t1_score", 32'(score), 32'h00);
      idle();
      chk("t1_pulse_end", 32'(pulse), 32'h0);
      cycle(1, 0, 0, 0, 0, 0);
      chk("t1_key_in_play", 32'(gs), 32'h2);

      // red, green, then a held level
      cycle(0, 1, 0, 0, 0, 0);
      chk("t2_red", 32'(score), 32'h01);
      idle();
      cycle(0, 1, 1, 0, 0, 0);
      chk("t2_green", 32'(score), 32'h03);
      repeat (25) cycle(0, 1, 0, 0, 0, 0);
      chk("t2_held", 32'(score), 32'h03);
      idle();
      apple(0);
      apple(0);
      chk("t4_pre", 32'(score), 32'h05);

      // wall hit coincident with an apple rise
      cycle(0, 1, 1, 1, 0, 0);
      chk("t4_status", 32'(gs), 32'h4);
      chk("t4_score", 32'(score), 32'h05);
      chk("t4_high", 32'(high), 32'h05);
      chk("t4_flash0", 32'(flash), 32'h1);
      for (int i = 1; i < 8; i++) begin
         idle();
         chk($sformatf("t4_flash%0d", i), 32'(flash), 32'(i < 4));
      end

      // early key ignored, key at saturation honoured
      wait_end(10);
      cycle(1, 0, 0, 0, 0, 0);
      chk("t5_early_key", 32'(gs), 32'h4);
      wait_end(HOLD);
      cycle(1, 0, 0, 0, 0, 0);
      chk("t5_to_start", 32'(gs), 32'h1);
      chk("t5_flash_off", 32'(flash), 32'h0);
      cycle(1, 0, 0, 0, 0, 0);
      chk("t5_play", 32'(gs), 32'h2);
      chk("t5_score_clr", 32'(score), 32'h00);
      repeat (3) apple(0);
      cycle(0, 0, 0, 0, 1, 0);
      chk("t5_end2", 32'(gs), 32'h4);
      chk("t5_score2", 32'(score), 32'h03);
      chk("t5_high_kept", 32'(high), 32'h05);
      wait_end(HOLD);
      cycle(1, 0, 0, 0, 0, 0);

      // carry and saturation
      cycle(1, 0, 0, 0, 0, 0);
      repeat (9) apple(0);
      chk("t3_09", 32'(score), 32'h09);
      apple(0);
      chk("t3_carry", 32'(score), 32'h10);
      repeat (44) apple(1);
      chk("t3_98", 32'(score), 32'h98);
      apple(1);
      chk("t3_sat_green", 32'(score), 32'h99);
      apple(0);
      chk("t3_sat_red", 32'(score), 32'h99);
      cycle(0, 0, 0, 0, 1, 0);
      chk("t3_high99", 32'(high), 32'h99);
      wait_end(HOLD);
      cycle(1, 0, 0, 0, 0, 0);

      // reset mid-game
      cycle(1, 0, 0, 0, 0, 0);
      repeat (7) apple(0);
      chk("t6_pre", 32'(score), 32'h07);
      cycle(0, 0, 0, 0, 0, 1);
      chk("t6_status", 32'(gs), 32'h1);
      chk("t6_score", 32'(score), 32'h00);
      chk("t6_high", 32'(high), 32'h00);
      chk("t6_pulse", 32'(pulse), 32'h0);

      // random play
      for (int i = 0; i < 3000; i++) begin
         bit k, b, t, w, h, r;
         k = ($urandom_range(0, 7) == 0);
         b = ($urandom_range(0, 2) == 0) ? !body : body;
         t = 1'($urandom_range(0, 1));
         w = ($urandom_range(0, 39) == 0);
         h = ($urandom_range(0, 59) == 0);
         r = ($urandom_range(0, 699) == 0);
         cycle(k, b, t, w, h, r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
